pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges four hazard sources into one prioritised set of per-stage stall/flush enables:
  - data-memory wait
  - multi-cycle divide/remainder handshake
  - taken branch/jump redirect from EX
  - load-use dependency
- Sits beside the forwarding unit. It owns every pipeline register enable/clear, so no other block drives them.
- Also keeps saturating stall/flush performance counters.

Parameters:
- RFIDX_W, `RFIDX_WIDTH (5): register index width.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rstn  in  1  asynchronous active-low reset.
- memreadE  in  1  EX-stage instruction is a load.
- rdE  in  RFIDX_W  EX destination register.
- rs1D  in  RFIDX_W  ID source register 1.
- rs2D  in  RFIDX_W  ID source register 2.
- branch_takenE  in  1  EX resolved a taken branch/jump.
- divE  in  1  EX holds a div/divu/rem/remu.
- div_done  in  1  divider result valid, one-cycle pulse.
- dmem_reqM  in  1  MEM stage issuing a data-memory access.
- dmem_ready  in  1  data memory accepts/completes the access this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- stallF, stallD, stallE, stallM, stallW  out  1 each  hold the named pipeline register.
- flushD, flushE, flushM  out  1 each  load a bubble into the named pipeline register.
- div_start  out  1  one-cycle divider launch pulse.
- stall_cnt  out  CNT_W  cycles with stallF=1.
- flush_cnt  out  CNT_W  cycles with flushD|flushE|flushM=1.

Behaviour:
- Registered state FSM: RUN, DIV_BUSY. Reset and power-up state is RUN.
- Control outputs are combinational from state and inputs. Counters are registered.
- Reset (rstn=0, asynchronous): state←RUN, stall_cnt←0, flush_cnt←0.
  - While in reset, all control outputs are forced 0.
  - Reset mid-divide abandons the operation. The divider shares rstn.
- Definitions:
  - mem_stall = dmem_reqM & ~dmem_ready
  - lu_hazard = memreadE & (rdE≠0) & (rdE==rs1D | rdE==rs2D)
- Priority, highest first, evaluated every cycle:
  1. mem_stall (any state): all five stalls=1, all flushes=0, div_start=0. State holds.
  2. State DIV_BUSY:
     - stallF=stallD=stallE=1, flushM=1, stallM=stallW=0.
     - On div_done=1: all stalls/flushes=0 that cycle, so the result advances EX→M. Next state RUN.
     - branch_takenE and lu_hazard are ignored in DIV_BUSY.
  3. RUN & divE:
     - div_start=1, stallF=stallD=stallE=1, flushM=1. Next state DIV_BUSY.
     - divE has priority over a simultaneous branch_takenE.
  4. RUN & branch_takenE: flushD=flushE=1, no stalls. Any lu_hazard is suppressed because the ID instruction is killed.
  5. RUN & lu_hazard: stallF=stallD=1, flushE=1. This gives exactly a 1-cycle bubble; the value is then forwarded from WB.
  6. Otherwise: all outputs 0.
- Latency:
  - Divide costs (divider latency + 1) cycles; div_start rises in the same cycle divE is seen.
  - Memory wait costs exactly the cycles dmem_ready=0.
  - mem_stall during DIV_BUSY freezes everything, including flushM=0. It resumes DIV_BUSY behaviour once dmem_ready=1. A div_done arriving during mem_stall is not lost: the divider must hold its result until the cycle after mem_stall drops.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNT_W−1 (no wrap).
  - cnt_clr has priority over increment.
  - Counting is suppressed while rstn=0.

Decomposition:
- Shared bus.v: RFIDX width macro; FSM state encodings RUN=1'b0, DIV_BUSY=1'b1 as `define.
- One sub-module, sat_counter (CNT_W, clr, inc), instantiated twice.
- The hazard priority logic stays in pipe_ctrl.

Test Plan:
- Reset mid-divide: divE=1 for one cycle, then rstn pulse → state RUN, counters 0, no stall afterwards with divE=0.
- Load-use: memreadE=1, rdE=5, rs1D=5 → stallF=stallD=flushE=1 for 1 cycle, stall_cnt=1. Repeat with rdE=0 → no stall.
- Branch vs load-use: branch_takenE=1 with lu_hazard true → flushD=flushE=1, stallF=0, flush_cnt+1.
- Divide with div_done 4 cycles after div_start:
  - div_start high exactly cycle 0.
  - stallF high cycles 0–3; cycle 4 all 0.
  - stall_cnt=4.
- Memory wait inside divide: dmem_ready=0 for 2 cycles during DIV_BUSY → all stalls=1, flushM=0 those cycles, then DIV_BUSY resumes; state unchanged.
- Saturation: CNT_W=4, hold stallF condition 20 cycles → stall_cnt stays 15; cnt_clr=1 → 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared constants for the pipeline stall/flush sequencer:
//   - RFIDX_WIDTH : register-file index width used by the hazard compare.
//   - ST_RUN / ST_DIV_BUSY : sequencer state encodings, kept as 1-bit
//     localparams so the existing RUN=0 / DIV_BUSY=1 encoding is preserved.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int RFIDX_WIDTH = 5;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_DIV_BUSY = 1'b1;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the pipeline performance counters.
//   Ports:
//     clk     : clock
//     rstn    : asynchronous active-low reset, clears the count
//     i_clr   : synchronous clear, wins over i_inc
//     i_inc   : count this cycle
//     o_count : current count, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is updated with <= only, so every flop samples
    // the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Merges data-memory
//   wait, multi-cycle divide, EX redirect and load-use hazards into one
//   prioritised set of pipeline-register enables/clears, and keeps saturating
//   stall/flush performance counters.
//   Ports:
//     clk, rstn                       : clock, async active-low reset
//     memreadE, rdE                   : EX load flag and destination
//     rs1D, rs2D                      : ID source registers
//     branch_takenE                   : EX resolved a taken branch/jump
//     divE, div_done                  : EX divide present, divider done pulse
//     dmem_reqM, dmem_ready           : MEM data-memory handshake
//     cnt_clr                         : synchronous clear of both counters
//     stallF..stallW                  : hold the named pipeline register
//     flushD, flushE, flushM          : bubble the named pipeline register
//     div_start                       : one-cycle divider launch
//     stall_cnt, flush_cnt            : performance counters
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RFIDX_W = RFIDX_WIDTH,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               memreadE,
    input  logic [RFIDX_W-1:0] rdE,
    input  logic [RFIDX_W-1:0] rs1D,
    input  logic [RFIDX_W-1:0] rs2D,
    input  logic               branch_takenE,
    input  logic               divE,
    input  logic               div_done,
    input  logic               dmem_reqM,
    input  logic               dmem_ready,
    input  logic               cnt_clr,
    output logic               stallF,
    output logic               stallD,
    output logic               stallE,
    output logic               stallM,
    output logic               stallW,
    output logic               flushD,
    output logic               flushE,
    output logic               flushM,
    output logic               div_start,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [0:0] r_state;
    logic [0:0] w_next_state;
    logic       w_mem_stall;
    logic       w_lu_hazard;

    assign w_mem_stall = dmem_reqM & ~dmem_ready;
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign w_lu_hazard = memreadE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // through this block can leave a signal unassigned and infer a latch.
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        stallW       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        div_start    = 1'b0;
        w_next_state = r_state;

        // Controls are held low throughout reset, not just after the edge.
        if (!rstn) begin
            w_next_state = ST_RUN;
        end else if (w_mem_stall) begin
            // Freeze everything, including the DIV_BUSY bubble into MEM; the
            // divider keeps any result until the memory wait clears.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
        end else if (r_state == ST_DIV_BUSY) begin
            if (div_done) begin
                // All enables open: the divide result advances EX->M now.
                w_next_state = ST_RUN;
            end else begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end
        end else if (divE) begin
            div_start    = 1'b1;
            stallF       = 1'b1;
            stallD       = 1'b1;
            stallE       = 1'b1;
            flushM       = 1'b1;
            w_next_state = ST_DIV_BUSY;
        end else if (branch_takenE) begin
            // The ID instruction is killed, so a load-use on it is moot.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_lu_hazard) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (cnt_clr),
        .i_inc   (stallF),
        .o_count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (cnt_clr),
        .i_inc   (flushD | flushE | flushM),
        .o_count (flush_cnt)
    );

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Directed testbench for pipe_ctrl. A 32-bit-counter instance covers the
//   control behaviour; a 4-bit-counter instance on the same inputs covers
//   counter saturation. Control vector order:
//   {stallF,stallD,stallE,stallM,stallW,flushD,flushE,flushM,div_start}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam logic [8:0] V_IDLE = 9'b000000000;
    localparam logic [8:0] V_MEM  = 9'b111110000;
    localparam logic [8:0] V_LU   = 9'b110000100;
    localparam logic [8:0] V_BR   = 9'b000001100;
    localparam logic [8:0] V_DIVS = 9'b111000011;
    localparam logic [8:0] V_DIVB = 9'b111000010;

    logic       clk = 1'b0;
    logic       rstn;
    logic       memreadE, branch_takenE, divE, div_done;
    logic       dmem_reqM, dmem_ready, cnt_clr;
    logic [4:0] rdE, rs1D, rs2D;

    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, div_start;
    logic [31:0] stall_cnt, flush_cnt;

    logic n_stallF, n_stallD, n_stallE, n_stallM, n_stallW;
    logic n_flushD, n_flushE, n_flushM, n_div_start;
    logic [3:0] n_stall_cnt, n_flush_cnt;

    logic [8:0] ctl;
    assign ctl = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, div_start};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.RFIDX_W(5), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .memreadE(memreadE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D),
        .branch_takenE(branch_takenE), .divE(divE), .div_done(div_done),
        .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .div_start(div_start),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.RFIDX_W(5), .CNT_W(4)) dut_narrow (
        .clk(clk), .rstn(rstn), .memreadE(memreadE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D),
        .branch_takenE(branch_takenE), .divE(divE), .div_done(div_done),
        .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .stallF(n_stallF), .stallD(n_stallD), .stallE(n_stallE), .stallM(n_stallM),
        .stallW(n_stallW), .flushD(n_flushD), .flushE(n_flushE), .flushM(n_flushM),
        .div_start(n_div_start), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        memreadE      = 1'b0;
        branch_takenE = 1'b0;
        divE          = 1'b0;
        div_done      = 1'b0;
        dmem_reqM     = 1'b0;
        dmem_ready    = 1'b1;
        cnt_clr       = 1'b0;
        rdE           = 5'd0;
        rs1D          = 5'd0;
        rs2D          = 5'd0;
    endtask

    task automatic clear_counters();
        drive_idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rstn = 1'b0;
        #3;
        dmem_reqM  = 1'b1;
        dmem_ready = 1'b0;
        #1;
        n_checks++;
        if (ctl !== V_IDLE) $display("FAIL reset_ctl: got %b want %b", ctl, V_IDLE);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else n_pass++;
        @(negedge clk);
        #2;
        rstn = 1'b1;
        #1;
        n_checks++;
        if (ctl !== V_MEM) $display("FAIL reset_release_ctl: got %b want %b", ctl, V_MEM);
        else n_pass++;
        tick();
        n_checks++;
        if (stall_cnt !== 32'd1) $display("FAIL reset_first_count: got %0d want 1", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_divide();
        clear_counters();
        divE = 1'b1;
        tick();
        n_checks++;
        if (ctl !== V_DIVB) $display("FAIL rmd_busy_ctl: got %b want %b", ctl, V_DIVB);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (ctl !== V_IDLE || stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL rmd_in_reset: got %b cnt %0d/%0d want %b cnt 0/0",
                     ctl, stall_cnt, flush_cnt, V_IDLE);
        else n_pass++;
        divE = 1'b0;
        rstn = 1'b1;
        #1;
        n_checks++;
        if (ctl !== V_IDLE) $display("FAIL rmd_after_reset_ctl: got %b want %b", ctl, V_IDLE);
        else n_pass++;
        tick();
        n_checks++;
        if (ctl !== V_IDLE || stall_cnt !== 32'd0)
            $display("FAIL rmd_after_tick: got %b cnt %0d want %b cnt 0", ctl, stall_cnt, V_IDLE);
        else n_pass++;
    endtask

    task automatic test_load_use();
        clear_counters();
        memreadE = 1'b1; rdE = 5'd5; rs1D = 5'd5; rs2D = 5'd7;
        #1;
        n_checks++;
        if (ctl !== V_LU) $display("FAIL lu_rs1_ctl: got %b want %b", ctl, V_LU);
        else n_pass++;
        tick();
        memreadE = 1'b0;
        #1;
        n_checks++;
        if (ctl !== V_IDLE || stall_cnt !== 32'd1 || flush_cnt !== 32'd1)
            $display("FAIL lu_after: got %b cnt %0d/%0d want %b cnt 1/1",
                     ctl, stall_cnt, flush_cnt, V_IDLE);
        else n_pass++;
        memreadE = 1'b1; rdE = 5'd9; rs1D = 5'd3; rs2D = 5'd9;
        #1;
        n_checks++;
        if (ctl !== V_LU) $display("FAIL lu_rs2_ctl: got %b want %b", ctl, V_LU);
        else n_pass++;
        rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
        #1;
        n_checks++;
        if (ctl !== V_IDLE) $display("FAIL lu_x0_ctl: got %b want %b", ctl, V_IDLE);
        else n_pass++;
        rdE = 5'd4; rs1D = 5'd5; rs2D = 5'd6;
        #1;
        n_checks++;
        if (ctl !== V_IDLE) $display("FAIL lu_nomatch_ctl: got %b want %b", ctl, V_IDLE);
        else n_pass++;
    endtask

    task automatic test_branch_vs_load_use();
        clear_counters();
        memreadE = 1'b1; rdE = 5'd5; rs1D = 5'd5; branch_takenE = 1'b1;
        #1;
        n_checks++;
        if (ctl !== V_BR) $display("FAIL br_lu_ctl: got %b want %b", ctl, V_BR);
        else n_pass++;
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0)
            $display("FAIL br_lu_cnt: got %0d/%0d want stall 0 flush 1", stall_cnt, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_divide();
        logic [8:0] exp_v [5];
        exp_v[0] = V_DIVS; exp_v[1] = V_DIVB; exp_v[2] = V_DIVB;
        exp_v[3] = V_DIVB; exp_v[4] = V_IDLE;
        clear_counters();
        divE = 1'b1;
        branch_takenE = 1'b1;
        for (int c = 0; c < 5; c++) begin
            div_done = (c == 4);
            #1;
            n_checks++;
            if (ctl !== exp_v[c]) $display("FAIL div_cycle%0d: got %b want %b", c, ctl, exp_v[c]);
            else n_pass++;
            tick();
        end
        drive_idle();
        #1;
        n_checks++;
        if (ctl !== V_IDLE || stall_cnt !== 32'd4 || flush_cnt !== 32'd4)
            $display("FAIL div_after: got %b cnt %0d/%0d want %b cnt 4/4",
                     ctl, stall_cnt, flush_cnt, V_IDLE);
        else n_pass++;
    endtask

    task automatic test_mem_in_divide();
        logic [8:0] exp_v [6];
        exp_v[0] = V_DIVS; exp_v[1] = V_DIVB; exp_v[2] = V_MEM;
        exp_v[3] = V_MEM;  exp_v[4] = V_DIVB; exp_v[5] = V_IDLE;
        clear_counters();
        divE = 1'b1;
        for (int c = 0; c < 6; c++) begin
            dmem_reqM  = (c == 2 || c == 3);
            dmem_ready = !(c == 2 || c == 3);
            div_done   = (c == 3 || c == 5);
            #1;
            n_checks++;
            if (ctl !== exp_v[c]) $display("FAIL memdiv_cycle%0d: got %b want %b", c, ctl, exp_v[c]);
            else n_pass++;
            tick();
        end
        drive_idle();
        #1;
        n_checks++;
        if (ctl !== V_IDLE || stall_cnt !== 32'd5 || flush_cnt !== 32'd3)
            $display("FAIL memdiv_after: got %b cnt %0d/%0d want %b cnt 5/3",
                     ctl, stall_cnt, flush_cnt, V_IDLE);
        else n_pass++;
    endtask

    task automatic test_mem_priority();
        clear_counters();
        dmem_reqM = 1'b1; dmem_ready = 1'b0;
        branch_takenE = 1'b1; memreadE = 1'b1; rdE = 5'd2; rs1D = 5'd2;
        #1;
        n_checks++;
        if (ctl !== V_MEM) $display("FAIL mem_over_branch: got %b want %b", ctl, V_MEM);
        else n_pass++;
        dmem_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl !== V_BR) $display("FAIL mem_ready_branch: got %b want %b", ctl, V_BR);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_saturation();
        clear_counters();
        dmem_reqM = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        n_checks++;
        if (n_stall_cnt !== 4'd15) $display("FAIL sat_narrow: got %0d want 15", n_stall_cnt);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 32'd20) $display("FAIL sat_wide: got %0d want 20", stall_cnt);
        else n_pass++;
        cnt_clr = 1'b1;
        tick();
        n_checks++;
        if (n_stall_cnt !== 4'd0 || stall_cnt !== 32'd0)
            $display("FAIL sat_clr: got %0d/%0d want 0/0", n_stall_cnt, stall_cnt);
        else n_pass++;
        cnt_clr = 1'b0;
        tick();
        n_checks++;
        if (n_stall_cnt !== 4'd1) $display("FAIL sat_restart: got %0d want 1", n_stall_cnt);
        else n_pass++;
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_reset_mid_divide();
        test_load_use();
        test_branch_vs_load_use();
        test_divide();
        test_mem_in_divide();
        test_mem_priority();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_ctrl
